multicycle_adder: RTL

//  Parametrised sequential ripple adder; successor to the 4-bit combinational FullAdder4bit.

---
 rtl/multicycle_adder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_adder.sv
// Sequential chunked ripple adder: adds two WIDTH-bit operands CHUNK bits per clock, LSB first.
// Optional build macro MULTICYCLE_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module multicycle_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULTICYCLE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int NC   = WIDTH / CHUNK;
  localparam int IDXW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {carry out of chunk MSB, carry into chunk MSB, chunk sum}.
  function automatic logic [CHUNK+1:0] chunk_add(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
    logic [CHUNK:0] t;
    logic           cmsb;
    t    = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    cmsb = t[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];
    return {t[CHUNK], cmsb, t[CHUNK-1:0]};
  endfunction

  state_t             state_r;
  state_t             state_nx_s;
  logic               accept_s;
  logic               last_s;
  logic [WIDTH-1:0]   op_a_r;
  logic [WIDTH-1:0]   op_b_r;
  logic [WIDTH-1:0]   acc_r;
  logic               carry_r;
  logic [IDXW-1:0]    idx_r;
  logic [WIDTH-1:0]   b_in_s;
  logic               cin_s;
  logic [CHUNK+1:0]   chunk_res_s;
  logic [CHUNK-1:0]   chunk_sum_s;
  logic               chunk_cmsb_s;
  logic               chunk_cout_s;
  logic [WIDTH-1:0]   acc_nx_s;
  logic [WIDTH-1:0]   op_a_sh_s;
  logic [WIDTH-1:0]   op_b_sh_s;

  // Operand conditioning at the sampling edge: subtraction is a + ~b + 1.
  always_comb begin
`ifdef MULTICYCLE_ADDER_SUB_EN
    if (sub) begin
      b_in_s = ~b;
      cin_s  = 1'b1;
    end else begin
      b_in_s = b;
      cin_s  = 1'b0;
    end
`else
    b_in_s = b;
    cin_s  = 1'b0;
`endif
  end

  // Current chunk sits in the low bits of the shifting operand registers.
  always_comb begin
    chunk_res_s  = chunk_add(op_a_r[CHUNK-1:0], op_b_r[CHUNK-1:0], carry_r);
    chunk_sum_s  = chunk_res_s[CHUNK-1:0];
    chunk_cmsb_s = chunk_res_s[CHUNK];
    chunk_cout_s = chunk_res_s[CHUNK+1];
  end

  // New chunk enters the accumulator at the top; after NC chunks it lands aligned.
  generate
    if (NC == 1) begin : g_single
      assign acc_nx_s  = chunk_sum_s;
      assign op_a_sh_s = {WIDTH{1'b0}};
      assign op_b_sh_s = {WIDTH{1'b0}};
    end else begin : g_multi
      assign acc_nx_s  = {chunk_sum_s, acc_r[WIDTH-1:CHUNK]};
      assign op_a_sh_s = {{CHUNK{1'b0}}, op_a_r[WIDTH-1:CHUNK]};
      assign op_b_sh_s = {{CHUNK{1'b0}}, op_b_r[WIDTH-1:CHUNK]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; DONE accepts a new start exactly like IDLE.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    last_s     = (idx_r == LAST_IDX);
    case (state_r)
      IDLE: begin
        if (start) begin
          accept_s   = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          accept_s   = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Operand latch, chunk sequencing and inter-cycle carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_r  <= {WIDTH{1'b0}};
      op_b_r  <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDXW{1'b0}};
    end else if (accept_s) begin
      op_a_r  <= a;
      op_b_r  <= b_in_s;
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= cin_s;
      idx_r   <= {IDXW{1'b0}};
    end else if (state_r == RUN) begin
      op_a_r  <= op_a_sh_s;
      op_b_r  <= op_b_sh_s;
      acc_r   <= acc_nx_s;
      carry_r <= chunk_cout_s;
      idx_r   <= idx_r + IDXW'(1);
    end else begin
      op_a_r  <= op_a_r;
      op_b_r  <= op_b_r;
      acc_r   <= acc_r;
      carry_r <= carry_r;
      idx_r   <= idx_r;
    end
  end

  // Registered handshake and result; results move only on the edge entering DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= {WIDTH{1'b0}};
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      busy <= (state_nx_s == RUN);
      done <= (state_nx_s == DONE);
      if ((state_r == RUN) && last_s) begin
        sum      <= acc_nx_s;
        carryout <= chunk_cout_s;
        overflow <= chunk_cout_s ^ chunk_cmsb_s;
      end else begin
        sum      <= sum;
        carryout <= carryout;
        overflow <= overflow;
      end
    end
  end

endmodule
